// File: rtl/hd44780_fifo.sv
// hd44780_fifo: single-clock FIFO on an inferred registered-read block RAM.
// Queues LCD command/data words between the host producer and the HD44780 bus
// sequencer. Provides occupancy, full/empty and programmable almost flags,
// sticky overflow/underflow, synchronous flush, and standard or FWFT read mode.
module hd44780_fifo #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 8,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 240,
    parameter int AEMPTY_THRESH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_L  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_L = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  hold;
    logic                  acc_wr;
    logic                  acc_rd;
    logic                  ram_rd;
    logic [ADDR_WIDTH:0]   ram_level;

    // Request acceptance and RAM read strobe; in FWFT the RAM feeds the output
    // register whenever it is empty or being popped and unread words remain.
    always_comb begin
        hold   = reset || flush;
        acc_wr = wr_en && !full_q && !hold;
        acc_rd = rd_en && !empty_q && !hold;
        if (FWFT != 0) begin
            ram_level = level_q - (ADDR_WIDTH+1)'(rd_valid_q);
            ram_rd    = (!rd_valid_q || acc_rd) && (ram_level != '0) && !hold;
        end else begin
            ram_level = level_q;
            ram_rd    = acc_rd;
        end
    end

    // Next-state for pointers, occupancy, registered flags and sticky errors.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(acc_wr);
        rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(ram_rd);
        level_d     = level_q + (ADDR_WIDTH+1)'(acc_wr) - (ADDR_WIDTH+1)'(acc_rd);
        if (FWFT != 0) begin
            rd_valid_d = (rd_valid_q && !acc_rd) || ram_rd;
        end else begin
            rd_valid_d = acc_rd;
        end
        overflow_d  = (overflow_q && !clr_err) || (wr_en && full_q && !hold);
        underflow_d = (underflow_q && !clr_err) || (rd_en && empty_q && !hold);
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            rd_valid_d = 1'b0;
        end
        full_d   = (level_d == DEPTH_L);
        afull_d  = (level_d >= AFULL_L);
        aempty_d = (level_d <= AEMPTY_L);
        if (FWFT != 0) begin
            empty_d = !rd_valid_d;
        end else begin
            empty_d = (level_d == '0);
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Block RAM with registered read port; the array and read register are never reset.
    always_ff @(posedge clk) begin
        if (acc_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
        if (ram_rd) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    assign full         = full_q;
    assign almost_full  = afull_q;
    assign empty        = empty_q;
    assign almost_empty = aempty_q;
    assign level        = level_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_hd44780_fifo.sv
// tb_hd44780_fifo: drives a standard-mode and an FWFT-mode FIFO with the same
// stimulus and compares both against queue-based reference models every cycle,
// plus a vector table and directed sequences for the corner cases.
module tb_hd44780_fifo;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        clr_err;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] wr_data;

    logic        s_full, s_afull, s_empty, s_aempty, s_rv, s_ovf, s_udf;
    logic [15:0] s_data;
    logic [4:0]  s_level;
    logic        f_full, f_afull, f_empty, f_aempty, f_rv, f_ovf, f_udf;
    logic [15:0] f_data;
    logic [4:0]  f_level;

    int tests_run;
    int tests_failed;

    logic [15:0] sq[$];
    logic [15:0] fq[$];
    bit          m_s_rv, m_s_ovf, m_s_udf;
    logic [15:0] m_s_dat;
    bit          m_f_rv, m_f_ovf, m_f_udf;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [15:0] d;
        int          lvl;
        bit          full;
        bit          af;
        bit          ovf;
        bit          udf;
        bit          rv;
        logic [15:0] dat;
    } vec_t;

    vec_t vecs[34];

    hd44780_fifo #(
        .DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(0), .AFULL_THRESH(12), .AEMPTY_THRESH(2)
    ) u_std (
        .clk(clk), .reset(reset), .flush(flush), .clr_err(clr_err),
        .wr_en(wr_en), .wr_data(wr_data), .full(s_full), .almost_full(s_afull),
        .rd_en(rd_en), .rd_data(s_data), .rd_valid(s_rv), .empty(s_empty),
        .almost_empty(s_aempty), .level(s_level), .overflow(s_ovf), .underflow(s_udf)
    );

    hd44780_fifo #(
        .DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(1), .AFULL_THRESH(12), .AEMPTY_THRESH(2)
    ) u_fw (
        .clk(clk), .reset(reset), .flush(flush), .clr_err(clr_err),
        .wr_en(wr_en), .wr_data(wr_data), .full(f_full), .almost_full(f_afull),
        .rd_en(rd_en), .rd_data(f_data), .rd_valid(f_rv), .empty(f_empty),
        .almost_empty(f_aempty), .level(f_level), .overflow(f_ovf), .underflow(f_udf)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: queues of words, visibility rules from the FIFO contract.
    task automatic modelEdge();
        bit aw;
        bit ar;
        int vis;
        if (reset || flush) begin
            sq.delete();
            fq.delete();
            m_s_rv = 0;
            m_f_rv = 0;
            if (reset || clr_err) begin
                m_s_ovf = 0; m_s_udf = 0; m_f_ovf = 0; m_f_udf = 0;
            end
        end else begin
            aw = wr_en && (sq.size() < 16);
            ar = rd_en && (sq.size() > 0);
            m_s_ovf = (m_s_ovf && !clr_err) || (wr_en && !aw);
            m_s_udf = (m_s_udf && !clr_err) || (rd_en && !ar);
            if (ar) m_s_dat = sq.pop_front();
            m_s_rv = ar;
            if (aw) sq.push_back(wr_data);

            aw = wr_en && (fq.size() < 16);
            ar = rd_en && m_f_rv;
            m_f_ovf = (m_f_ovf && !clr_err) || (wr_en && !aw);
            m_f_udf = (m_f_udf && !clr_err) || (rd_en && !ar);
            vis = fq.size() - (ar ? 1 : 0);
            if (ar) void'(fq.pop_front());
            if (aw) fq.push_back(wr_data);
            m_f_rv = (vis > 0);
        end
    endtask

    task automatic checkOutput();
        int sl;
        int fl;
        sl = sq.size();
        fl = fq.size();
        chk("std level",  32'(s_level), 32'(sl));
        chk("std full",   32'(s_full),  32'(sl == 16));
        chk("std empty",  32'(s_empty), 32'(sl == 0));
        chk("std afull",  32'(s_afull), 32'(sl >= 12));
        chk("std aempty", 32'(s_aempty), 32'(sl <= 2));
        chk("std ovf",    32'(s_ovf),   32'(m_s_ovf));
        chk("std udf",    32'(s_udf),   32'(m_s_udf));
        chk("std rvalid", 32'(s_rv),    32'(m_s_rv));
        if (m_s_rv) chk("std rdata", 32'(s_data), 32'(m_s_dat));
        chk("fw level",   32'(f_level), 32'(fl));
        chk("fw full",    32'(f_full),  32'(fl == 16));
        chk("fw empty",   32'(f_empty), 32'(!m_f_rv));
        chk("fw afull",   32'(f_afull), 32'(fl >= 12));
        chk("fw aempty",  32'(f_aempty), 32'(fl <= 2));
        chk("fw ovf",     32'(f_ovf),   32'(m_f_ovf));
        chk("fw udf",     32'(f_udf),   32'(m_f_udf));
        chk("fw rvalid",  32'(f_rv),    32'(m_f_rv));
        if (m_f_rv) chk("fw rdata", 32'(f_data), 32'(fq[0]));
    endtask

    // One clock: drive inputs, let the edge happen, update model, compare on the falling edge.
    task automatic applyStimulus(input bit r, input bit f, input bit c, input bit w,
                                 input bit rd, input logic [15:0] d);
        reset   = r;
        flush   = f;
        clr_err = c;
        wr_en   = w;
        rd_en   = rd;
        wr_data = d;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 16'h0);
    endtask

    initial begin
        int lv;
        int wv;
        tests_run    = 0;
        tests_failed = 0;
        reset = 1; flush = 0; clr_err = 0; wr_en = 0; rd_en = 0; wr_data = '0;

        for (int i = 0; i < 17; i++) begin
            lv = (i < 16) ? i + 1 : 16;
            vecs[i] = '{wr: 1, rd: 0, d: 16'h0100 + 16'(i), lvl: lv, full: (lv == 16),
                        af: (lv >= 12), ovf: (i == 16), udf: 0, rv: 0, dat: 16'h0};
        end
        for (int j = 0; j < 17; j++) begin
            lv = (j < 16) ? 15 - j : 0;
            vecs[17 + j] = '{wr: 0, rd: 1, d: 16'h0, lvl: lv, full: 0, af: (lv >= 12),
                             ovf: 1, udf: (j == 16), rv: (j < 16), dat: 16'h0100 + 16'(j)};
        end

        // Reset state.
        applyStimulus(1, 0, 0, 0, 0, 16'h0);
        chk("reset level", 32'(s_level), 32'd0);
        chk("reset empty", 32'(s_empty), 32'd1);
        chk("reset aempty", 32'(s_aempty), 32'd1);
        chk("reset fw empty", 32'(f_empty), 32'd1);

        // Fill and drain from the vector table (standard-mode expectations).
        for (int k = 0; k < 34; k++) begin
            applyStimulus(0, 0, 0, vecs[k].wr, vecs[k].rd, vecs[k].d);
            chk("vec level", 32'(s_level), 32'(vecs[k].lvl));
            chk("vec full",  32'(s_full),  32'(vecs[k].full));
            chk("vec afull", 32'(s_afull), 32'(vecs[k].af));
            chk("vec ovf",   32'(s_ovf),   32'(vecs[k].ovf));
            chk("vec udf",   32'(s_udf),   32'(vecs[k].udf));
            chk("vec rvalid", 32'(s_rv),   32'(vecs[k].rv));
            if (vecs[k].rv) chk("vec rdata", 32'(s_data), 32'(vecs[k].dat));
        end

        // Simultaneous read/write at level 5, at full and at empty.
        applyStimulus(1, 0, 0, 0, 0, 16'h0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 0, 16'h0200 + 16'(i));
        idle(1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 1, 16'h0300 + 16'(i));
        chk("simul level5", 32'(s_level), 32'd5);
        for (int i = 0; i < 11; i++) applyStimulus(0, 0, 0, 1, 0, 16'h0400 + 16'(i));
        chk("simul at full", 32'(s_full), 32'd1);
        applyStimulus(0, 0, 0, 1, 1, 16'hDEAD);
        chk("simul full level", 32'(s_level), 32'd15);
        chk("simul full ovf", 32'(s_ovf), 32'd1);
        applyStimulus(1, 0, 0, 0, 0, 16'h0);
        applyStimulus(0, 0, 0, 1, 1, 16'h0777);
        chk("simul empty level", 32'(s_level), 32'd1);
        chk("simul empty udf", 32'(s_udf), 32'd1);
        idle(3);

        // FWFT latency and back-to-back pops.
        applyStimulus(1, 0, 0, 0, 0, 16'h0);
        applyStimulus(0, 0, 0, 1, 0, 16'hABCD);
        chk("fwft first edge rv", 32'(f_rv), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 16'h0);
        chk("fwft second edge rv", 32'(f_rv), 32'd1);
        chk("fwft second edge data", 32'(f_data), 32'hABCD);
        applyStimulus(0, 0, 0, 0, 1, 16'h0);
        applyStimulus(0, 0, 0, 1, 0, 16'h1111);
        applyStimulus(0, 0, 0, 1, 0, 16'h2222);
        applyStimulus(0, 0, 0, 1, 0, 16'h3333);
        idle(1);
        chk("fwft head 1", 32'(f_data), 32'h1111);
        applyStimulus(0, 0, 0, 0, 1, 16'h0);
        chk("fwft head 2", 32'(f_data), 32'h2222);
        applyStimulus(0, 0, 0, 0, 1, 16'h0);
        chk("fwft head 3", 32'(f_data), 32'h3333);
        applyStimulus(0, 0, 0, 0, 1, 16'h0);
        chk("fwft drained rv", 32'(f_rv), 32'd0);
        chk("fwft drained empty", 32'(f_empty), 32'd1);

        // Wrap: 40 sequential words with a random read/write mix.
        applyStimulus(1, 0, 0, 0, 0, 16'h0);
        wv = 0;
        for (int i = 0; i < 200 && wv < 40; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                applyStimulus(0, 0, 0, 1, ($urandom_range(0, 2) == 0), 16'(wv));
                wv++;
            end else begin
                applyStimulus(0, 0, 0, 0, ($urandom_range(0, 1) == 1), 16'h0);
            end
        end
        chk("wrap all written", 32'(wv), 32'd40);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 1, 16'h0);

        // Long random run including flushes and error clears.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(0, ($urandom_range(0, 39) == 0), ($urandom_range(0, 29) == 0),
                          ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
                          16'($urandom));
        end

        // Flush and reset mid-burst at level 7 with sticky flags set.
        applyStimulus(1, 0, 0, 0, 0, 16'h0);
        applyStimulus(0, 0, 0, 0, 1, 16'h0);
        for (int i = 0; i < 17; i++) applyStimulus(0, 0, 0, 1, 0, 16'h0500 + 16'(i));
        for (int i = 0; i < 9; i++) applyStimulus(0, 0, 0, 0, 1, 16'h0);
        chk("pre-flush level", 32'(s_level), 32'd7);
        applyStimulus(0, 1, 0, 1, 1, 16'hBEEF);
        chk("flush level", 32'(s_level), 32'd0);
        chk("flush empty", 32'(s_empty), 32'd1);
        chk("flush rv", 32'(s_rv), 32'd0);
        chk("flush fw level", 32'(f_level), 32'd0);
        chk("flush keeps ovf", 32'(s_ovf), 32'd1);
        chk("flush keeps udf", 32'(s_udf), 32'd1);
        applyStimulus(0, 0, 1, 0, 0, 16'h0);
        chk("clr_err ovf", 32'(s_ovf), 32'd0);
        chk("clr_err udf", 32'(f_udf), 32'd0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 1, 0, 16'h0600 + 16'(i));
        applyStimulus(0, 0, 0, 0, 1, 16'h0);
        applyStimulus(0, 0, 0, 0, 1, 16'h0);
        applyStimulus(0, 0, 0, 1, 0, 16'h0700);
        applyStimulus(0, 0, 0, 1, 0, 16'h0701);
        applyStimulus(1, 0, 0, 1, 1, 16'h0702);
        chk("reset level", 32'(f_level), 32'd0);
        chk("reset rv", 32'(f_rv), 32'd0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
